i2c_wr_arbiter: RTL and testbench

Round-robin arbiter that shares one I2C write master between NREQ requesters. The master has a 7-bit address, 8-bit data, a start strobe and a ready flag. The arbiter sits between the requesters and the master. It latches the winning request, launches the frame, tracks master busy/idle through ready, and returns a per-requester done or error pulse. A watchdog recovers from a master that never starts or never finishes.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/rr_pick.sv | 32 +++
 rtl/i2c_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_i2c_wr_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C write-path blocks: field widths, arbiter FSM states
// and the address/data payload latched for the master.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_DATA_W-1:0] data;
  } i2c_wr_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after index 'last',
// wrapping modulo N. Returns valid, a one-hot winner and its index.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Scan offsets 1..N so 'last' itself has the lowest priority.
  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last) + k) % N);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_wr_arbiter.sv
// Round-robin arbiter sharing one I2C write master between NREQ requesters,
// with a watchdog on both the start handshake and the frame completion.
module i2c_wr_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*I2C_ADDR_W-1:0] req_addr,
  input  logic [NREQ*I2C_DATA_W-1:0] req_data,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [NREQ-1:0]            err,
  output logic                       busy,
  output logic [I2C_ADDR_W-1:0]      m_addr,
  output logic [I2C_DATA_W-1:0]      m_data,
  output logic                       m_start,
  input  logic                       m_ready
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;
  i2c_wr_t         frame_q, frame_d;
  logic [IW-1:0]   last_q, last_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            pick_valid;
  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;

  logic [I2C_ADDR_W-1:0] addr_arr [NREQ];
  logic [I2C_DATA_W-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[I2C_ADDR_W*i +: I2C_ADDR_W];
    assign data_arr[i] = req_data[I2C_DATA_W*i +: I2C_DATA_W];
  end

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .last   (last_q),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      frame_q <= '0;
      last_q  <= IW'(NREQ - 1);
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      frame_q <= frame_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  // gnt_q doubles as the one-hot of the current winner for done/err.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    frame_d = frame_q;
    last_d  = last_q;
    timer_d = timer_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid && m_ready) begin
          frame_d.addr = addr_arr[pick_idx];
          frame_d.data = data_arr[pick_idx];
          gnt_d        = pick_onehot;
          last_d       = pick_idx;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        start_d = 1'b1;
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!m_ready) begin
          timer_d = '0;
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = gnt_q;
          state_d = RELEASE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (m_ready) begin
          done_d  = gnt_q;
          state_d = RELEASE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = gnt_q;
          state_d = RELEASE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RELEASE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign m_start = start_q;
  assign m_addr  = frame_q.addr;
  assign m_data  = frame_q.data;

endmodule

// File: tb/tb_i2c_wr_arbiter.sv
// Directed bench for i2c_wr_arbiter: single frame, contention, fairness,
// both watchdog paths, master-not-ready and reset mid-frame.
module tb_i2c_wr_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned NORM_N  = 22;

  localparam logic [6:0] EA [4] = '{7'h10, 7'h11, 7'h1A, 7'h13};
  localparam logic [7:0] ED [4] = '{8'hA0, 8'hA1, 8'h55, 8'hA3};

  logic            clk;
  logic            rst;
  logic [3:0]      req;
  logic [27:0]     req_addr;
  logic [31:0]     req_data;
  logic [3:0]      gnt, done, err;
  logic            busy;
  logic [6:0]      m_addr;
  logic [7:0]      m_data;
  logic            m_start;
  logic            m_ready = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  // Master model: 0 normal 20-cycle frame, 1 never starts, 2 never finishes, 3 held busy.
  int mode = 0;
  int cnt  = 0;
  int start_cnt = 0;
  int viol      = 0;
  logic prev_start = 1'b0;

  i2c_wr_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .m_addr   (m_addr),
    .m_data   (m_data),
    .m_start  (m_start),
    .m_ready  (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    case (mode)
      0: begin
        if (m_start && m_ready) begin
          m_ready <= 1'b0;
          cnt     <= 20;
        end else if (cnt > 1) begin
          cnt <= cnt - 1;
        end else begin
          cnt     <= 0;
          m_ready <= 1'b1;
        end
      end
      1: m_ready <= 1'b1;
      2: if (m_start) m_ready <= 1'b0;
      default: m_ready <= 1'b0;
    endcase
  end

  // Protocol monitor: one-hot outputs, exclusive done/err, single-cycle start.
  always @(negedge clk) begin
    if (rst) begin
      if (!$onehot0(gnt) || !$onehot0(done) || !$onehot0(err) || ((done & err) != 4'b0))
        viol <= viol + 1;
      if (m_start && prev_start) viol <= viol + 1;
      if (m_start) start_cnt <= start_cnt + 1;
    end
    prev_start <= m_start;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int budget, output int n);
    n = 0;
    while (m_start !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_ev(input int budget, output int n, output logic [3:0] d, output logic [3:0] e);
    n = 0;
    d = '0;
    e = '0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if ((done | err) != 4'b0) begin
        d = done;
        e = err;
        break;
      end
    end
  endtask

  // One frame for requester idx: start seen, grant/payload, then done or err after exp_n cycles.
  task automatic serve(input int unsigned idx, input int exp_n, input bit exp_err,
                       input bit drop, input string tag);
    int n;
    logic [3:0] d, e;
    logic [3:0] oh;
    oh = 4'(1 << idx);
    wait_start(40, n);
    check({tag, "_start"}, 32'(m_start), 32'd1);
    check({tag, "_gnt"},   32'(gnt),     32'(oh));
    check({tag, "_addr"},  32'(m_addr),  32'(EA[2'(idx)]));
    check({tag, "_data"},  32'(m_data),  32'(ED[2'(idx)]));
    wait_ev(exp_n + 10, n, d, e);
    check({tag, "_lat"},  32'(n), 32'(exp_n));
    check({tag, "_done"}, 32'(d), exp_err ? 32'd0 : 32'(oh));
    check({tag, "_err"},  32'(e), exp_err ? 32'(oh) : 32'd0);
    if (drop) req[2'(idx)] = 1'b0;
  endtask

  initial begin
    int s0;
    rst      = 1'b0;
    req      = '0;
    req_addr = {EA[3], EA[2], EA[1], EA[0]};
    req_data = {ED[3], ED[2], ED[1], ED[0]};
    repeat (3) @(negedge clk);

    check("rst_gnt",   32'(gnt),     32'd0);
    check("rst_done",  32'(done),    32'd0);
    check("rst_err",   32'(err),     32'd0);
    check("rst_start", 32'(m_start), 32'd0);
    check("rst_addr",  32'(m_addr),  32'd0);
    check("rst_data",  32'(m_data),  32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single request from requester 2.
    req = 4'b0100;
    @(negedge clk);
    check("single_gnt_early",   32'(gnt),     32'h4);
    check("single_addr_early",  32'(m_addr),  32'h1A);
    check("single_data_early",  32'(m_data),  32'h55);
    check("single_start_early", 32'(m_start), 32'd0);
    check("single_busy",        32'(busy),    32'd1);
    serve(2, NORM_N, 1'b0, 1'b1, "single");
    @(negedge clk);
    #1;
    check("single_rel_gnt",  32'(gnt),       32'd0);
    check("single_rel_busy", 32'(busy),      32'd0);
    check("single_rel_done", 32'(done),      32'd0);
    check("single_hold",     32'(m_addr),    32'h1A);
    check("single_starts",   32'(start_cnt), 32'd1);

    // Contention from reset: 1 then 3.
    rst = 1'b0;
    req = 4'b1010;
    repeat (2) @(negedge clk);
    #1;
    s0 = start_cnt;
    rst = 1'b1;
    serve(1, NORM_N, 1'b0, 1'b1, "cont1");
    serve(3, NORM_N, 1'b0, 1'b1, "cont3");
    @(negedge clk);
    #1;
    check("cont_starts", 32'(start_cnt - s0), 32'd2);

    // Fairness with all four held.
    req = 4'b1111;
    serve(0, NORM_N, 1'b0, 1'b0, "fair0");
    serve(1, NORM_N, 1'b0, 1'b0, "fair1");
    serve(2, NORM_N, 1'b0, 1'b0, "fair2");
    serve(3, NORM_N, 1'b0, 1'b0, "fair3");
    serve(0, NORM_N, 1'b0, 1'b0, "fair4");
    serve(1, NORM_N, 1'b0, 1'b0, "fair5");
    req = 4'b0000;
    @(negedge clk);

    // Master never starts: err from WAIT_BUSY, then next requester served.
    mode = 1;
    req  = 4'b1100;
    serve(2, TIMEOUT, 1'b1, 1'b1, "to_busy");
    mode = 0;
    serve(3, NORM_N, 1'b0, 1'b1, "after_to");

    // Master never finishes: err from WAIT_DONE.
    mode = 2;
    req  = 4'b0010;
    serve(1, TIMEOUT + 2, 1'b1, 1'b1, "to_done");
    mode = 0;
    repeat (2) @(negedge clk);

    // Master not ready: no grant until it is.
    mode = 3;
    @(negedge clk);
    req = 4'b0001;
    repeat (5) @(negedge clk);
    check("nrdy_gnt",  32'(gnt),  32'd0);
    check("nrdy_busy", 32'(busy), 32'd0);
    mode = 0;
    serve(0, NORM_N, 1'b0, 1'b1, "nrdy");

    // Reset during WAIT_DONE, then pending requests restart at requester 0.
    req = 4'b0011;
    wait_start(40, s0);
    check("mid_gnt", 32'(gnt), 32'h2);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_gnt_clr",   32'(gnt),     32'd0);
    check("mid_start_clr", 32'(m_start), 32'd0);
    check("mid_done_clr",  32'(done),    32'd0);
    check("mid_err_clr",   32'(err),     32'd0);
    check("mid_busy_clr",  32'(busy),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    serve(0, NORM_N, 1'b0, 1'b1, "post0");
    serve(1, NORM_N, 1'b0, 1'b1, "post1");
    @(negedge clk);
    #1;
    check("protocol_viol", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
